// File: rtl/dual_slope_sequencer.sv
// rtl/dual_slope_sequencer.sv - dual-slope voltmeter conversion sequencer
// Sequences clear, fixed integrate, break, reference deintegrate and result latch.
module dual_slope_sequencer #(
  parameter int INT_CYCLES = 2048,
  parameter int MAX_COUNT  = 4095
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        comparator_i,
  input  logic [11:0] measurement_count_i,
  output logic        measurement_en_o,
  output logic        measurement_clear_o,
  output logic        integrate_sw_o,
  output logic        deintegrate_sw_o,
  output logic        busy_o,
  output logic [11:0] result_o,
  output logic        result_valid_o,
  output logic        overrange_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_INTEGRATE,
    S_BREAK,
    S_DEINTEGRATE,
    S_DONE
  } state_t;

  localparam logic [11:0] INT_LAST  = 12'(INT_CYCLES - 1);
  localparam logic [11:0] COUNT_MAX = 12'(MAX_COUNT);

  state_t      state;
  logic [11:0] int_timer;
  logic        comp_meta;
  logic        comp_s;
  logic        at_max;

  // comparator_i comes straight from the analog front end, unrelated to clk_i
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      comp_meta <= 1'b0;
      comp_s    <= 1'b0;
    end else begin
      comp_meta <= comparator_i;
      comp_s    <= comp_meta;
    end
  end

  assign at_max = (measurement_count_i == COUNT_MAX);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      int_timer   <= '0;
      result_o    <= '0;
      overrange_o <= 1'b0;
    end else if (abort_i && (state != S_IDLE)) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i && !abort_i) state <= S_CLEAR;
        end
        S_CLEAR: begin
          int_timer   <= '0;
          overrange_o <= 1'b0;
          state       <= S_INTEGRATE;
        end
        S_INTEGRATE: begin
          int_timer <= int_timer + 12'd1;
          if (int_timer == INT_LAST) state <= S_BREAK;
        end
        S_BREAK: begin
          state <= S_DEINTEGRATE;
        end
        S_DEINTEGRATE: begin
          // a trip takes priority over the limit so an exact MAX_COUNT is not overrange
          if (!comp_s) begin
            result_o <= measurement_count_i;
            state    <= S_DONE;
          end else if (at_max) begin
            result_o    <= COUNT_MAX;
            overrange_o <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o              = (state != S_IDLE);
  assign measurement_clear_o = (state == S_CLEAR);
  assign integrate_sw_o      = (state == S_INTEGRATE);
  assign deintegrate_sw_o    = (state == S_DEINTEGRATE);
  assign result_valid_o      = (state == S_DONE);
  assign measurement_en_o    = deintegrate_sw_o & comp_s & ~at_max;

endmodule

// File: tb/tb_dual_slope_sequencer.sv
// tb/tb_dual_slope_sequencer.sv - self-checking bench for dual_slope_sequencer
// Expected timing and results are derived arithmetically from the conversion rules.
module tb_dual_slope_sequencer;

  localparam int INT_C = 16;
  localparam int MAXC  = 4095;
  localparam int BUDGET = 6000;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic        abort_i;
  logic        comparator_i;
  logic [11:0] measurement_count_i;
  logic        measurement_en_o;
  logic        measurement_clear_o;
  logic        integrate_sw_o;
  logic        deintegrate_sw_o;
  logic        busy_o;
  logic [11:0] result_o;
  logic        result_valid_o;
  logic        overrange_o;

  int n_cmp = 0;
  int n_bad = 0;

  int          obs_end, obs_clear_cnt, obs_clear_first, obs_int_cnt, obs_int_first;
  int          obs_deint_first, obs_en_cnt, obs_valid_cnt, obs_valid_cycle;
  logic [11:0] obs_result, obs_result_end;
  logic        obs_ovr, obs_ovr_end, obs_ovr_c2, obs_sw_end;

  int          last_result = 0;

  dual_slope_sequencer #(.INT_CYCLES(INT_C), .MAX_COUNT(MAXC)) dut (
    .clk_i               (clk_i),
    .rst_n_i             (rst_n_i),
    .start_i             (start_i),
    .abort_i             (abort_i),
    .comparator_i        (comparator_i),
    .measurement_count_i (measurement_count_i),
    .measurement_en_o    (measurement_en_o),
    .measurement_clear_o (measurement_clear_o),
    .integrate_sw_o      (integrate_sw_o),
    .deintegrate_sw_o    (deintegrate_sw_o),
    .busy_o              (busy_o),
    .result_o            (result_o),
    .result_valid_o      (result_valid_o),
    .overrange_o         (overrange_o)
  );

  always #5 clk_i = ~clk_i;

  // external 12-bit measurement counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) measurement_count_i <= '0;
    else if (measurement_clear_o) measurement_count_i <= '0;
    else if (measurement_en_o) measurement_count_i <= measurement_count_i + 12'd1;
  end

  always @(negedge clk_i) begin
    n_cmp++;
    if (integrate_sw_o && deintegrate_sw_o) begin
      n_bad++;
      $display("FAIL switch_overlap: int=%0b deint=%0b want not both 1", integrate_sw_o, deintegrate_sw_o);
    end
  end

  // Cycle 0 is the cycle start_i is presented in IDLE; comparator_i stays high
  // for the first INT_C+1+n_high cycles so comp_s is high for n_high DEINTEGRATE cycles.
  task automatic drive_conv(input int n_high, input int abort_at, input bit start_in_deint);
    obs_end = -1; obs_clear_cnt = 0; obs_clear_first = -1; obs_int_cnt = 0;
    obs_int_first = -1; obs_deint_first = -1; obs_en_cnt = 0; obs_valid_cnt = 0;
    obs_valid_cycle = -1; obs_ovr_c2 = 1'b1; obs_sw_end = 1'b1;
    start_i = 1'b1;
    abort_i = (abort_at == 0);
    comparator_i = 1'b1;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk_i);
      if (measurement_clear_o) begin
        obs_clear_cnt++;
        if (obs_clear_first < 0) obs_clear_first = c;
      end
      if (integrate_sw_o) begin
        obs_int_cnt++;
        if (obs_int_first < 0) obs_int_first = c;
      end
      if (deintegrate_sw_o && obs_deint_first < 0) obs_deint_first = c;
      if (measurement_en_o) obs_en_cnt++;
      if (c == 2) obs_ovr_c2 = overrange_o;
      if (result_valid_o) begin
        obs_valid_cnt++;
        obs_valid_cycle = c;
        obs_result = result_o;
        obs_ovr = overrange_o;
      end
      if (c > 0 && !busy_o) begin
        obs_end = c;
        obs_result_end = result_o;
        obs_ovr_end = overrange_o;
        obs_sw_end = integrate_sw_o | deintegrate_sw_o;
        break;
      end
      @(posedge clk_i);
      #1;
      start_i = start_in_deint && deintegrate_sw_o;
      abort_i = (c + 1 == abort_at);
      comparator_i = (c + 1 < INT_C + 1 + n_high);
    end
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; comparator_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if ({busy_o, integrate_sw_o, deintegrate_sw_o, measurement_en_o, measurement_clear_o,
         result_valid_o, overrange_o} !== 7'b0 || result_o !== 12'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: busy=%0b result=%0d ovr=%0b want all 0", busy_o, result_o, overrange_o);
    end
    rst_n_i = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%0b want 0", busy_o);
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 4; k++) begin
      int n = (k == 0) ? 10 : int'($urandom_range(1, 300));
      @(posedge clk_i); #1;
      drive_conv(n, -1, 1'b0);
      n_cmp++;
      if (obs_end < 0) begin
        n_bad++;
        $display("FAIL basic_timeout: no return to idle in %0d cycles (n=%0d)", BUDGET, n);
      end
      n_cmp++;
      if (obs_clear_first !== 1 || obs_clear_cnt !== 1) begin
        n_bad++;
        $display("FAIL basic_clear: first=%0d count=%0d want first=1 count=1", obs_clear_first, obs_clear_cnt);
      end
      n_cmp++;
      if (obs_int_first !== 2 || obs_int_cnt !== INT_C) begin
        n_bad++;
        $display("FAIL basic_integrate: first=%0d len=%0d want first=2 len=%0d", obs_int_first, obs_int_cnt, INT_C);
      end
      n_cmp++;
      if (obs_deint_first !== INT_C + 3) begin
        n_bad++;
        $display("FAIL basic_break_gap: deint starts %0d want %0d", obs_deint_first, INT_C + 3);
      end
      n_cmp++;
      if (obs_valid_cnt !== 1 || obs_valid_cycle !== INT_C + 4 + n) begin
        n_bad++;
        $display("FAIL basic_latency: valid count=%0d at %0d want 1 at %0d", obs_valid_cnt, obs_valid_cycle, INT_C + 4 + n);
      end
      n_cmp++;
      if (obs_result !== 12'(n) || obs_ovr !== 1'b0 || obs_en_cnt !== n) begin
        n_bad++;
        $display("FAIL basic_result: result=%0d ovr=%0b en=%0d want %0d/0/%0d", obs_result, obs_ovr, obs_en_cnt, n, n);
      end
      last_result = n;
    end
  endtask

  task automatic test_zero();
    @(posedge clk_i); #1;
    drive_conv(0, -1, 1'b0);
    n_cmp++;
    if (obs_valid_cnt !== 1 || obs_valid_cycle !== INT_C + 4) begin
      n_bad++;
      $display("FAIL zero_valid: count=%0d at %0d want 1 at %0d", obs_valid_cnt, obs_valid_cycle, INT_C + 4);
    end
    n_cmp++;
    if (obs_result !== 12'd0 || obs_en_cnt !== 0) begin
      n_bad++;
      $display("FAIL zero_result: result=%0d en=%0d want 0/0", obs_result, obs_en_cnt);
    end
    last_result = 0;
  endtask

  task automatic test_overrange();
    @(posedge clk_i); #1;
    drive_conv(5000, -1, 1'b0);
    n_cmp++;
    if (obs_result !== 12'(MAXC) || obs_ovr !== 1'b1 || obs_en_cnt !== MAXC) begin
      n_bad++;
      $display("FAIL ovr_result: result=%0d ovr=%0b en=%0d want %0d/1/%0d", obs_result, obs_ovr, obs_en_cnt, MAXC, MAXC);
    end
    n_cmp++;
    if (obs_valid_cycle !== INT_C + 4 + MAXC || obs_ovr_end !== 1'b1) begin
      n_bad++;
      $display("FAIL ovr_timing: valid at %0d sticky=%0b want %0d/1", obs_valid_cycle, obs_ovr_end, INT_C + 4 + MAXC);
    end
    @(posedge clk_i); #1;
    drive_conv(3, -1, 1'b0);
    n_cmp++;
    if (obs_ovr_c2 !== 1'b0 || obs_result !== 12'd3 || obs_ovr !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_clear: ovr_after_clear=%0b result=%0d ovr=%0b want 0/3/0", obs_ovr_c2, obs_result, obs_ovr);
    end
    last_result = 3;
  endtask

  task automatic test_abort();
    @(posedge clk_i); #1;
    drive_conv(20, 6, 1'b0);
    n_cmp++;
    if (obs_end !== 7 || obs_int_cnt !== 5 || obs_sw_end !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_integrate: idle at %0d int_len=%0d sw=%0b want 7/5/0", obs_end, obs_int_cnt, obs_sw_end);
    end
    n_cmp++;
    if (obs_valid_cnt !== 0 || obs_result_end !== 12'(last_result) || obs_ovr_end !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_retain: valid=%0d result=%0d ovr=%0b want 0/%0d/0", obs_valid_cnt, obs_result_end, obs_ovr_end, last_result);
    end
    @(posedge clk_i); #1;
    drive_conv(50, INT_C + 5, 1'b0);
    n_cmp++;
    if (obs_end !== INT_C + 6 || obs_valid_cnt !== 0 || obs_en_cnt !== 3 ||
        obs_result_end !== 12'(last_result)) begin
      n_bad++;
      $display("FAIL abort_deint: idle at %0d valid=%0d en=%0d result=%0d want %0d/0/3/%0d",
               obs_end, obs_valid_cnt, obs_en_cnt, obs_result_end, INT_C + 6, last_result);
    end
  endtask

  task automatic test_start_ignored();
    int n = int'($urandom_range(5, 40));
    @(posedge clk_i); #1;
    drive_conv(n, -1, 1'b1);
    n_cmp++;
    if (obs_valid_cnt !== 1 || obs_result !== 12'(n) || obs_valid_cycle !== INT_C + 4 + n) begin
      n_bad++;
      $display("FAIL start_in_deint: valid=%0d result=%0d at %0d want 1/%0d/%0d", obs_valid_cnt, obs_result, obs_valid_cycle, n, INT_C + 4 + n);
    end
    last_result = n;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_cmp++;
      if (busy_o !== 1'b0) begin
        n_bad++;
        $display("FAIL start_not_queued: busy=%0b want 0", busy_o);
      end
    end
    @(posedge clk_i); #1;
    start_i = 1'b1; abort_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; abort_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (busy_o !== 1'b0 || measurement_clear_o !== 1'b0) begin
      n_bad++;
      $display("FAIL start_abort_idle: busy=%0b clear=%0b want 0/0", busy_o, measurement_clear_o);
    end
  endtask

  task automatic test_reset_mid();
    bit reached = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b1; comparator_i = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (deintegrate_sw_o) begin
        reached = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!reached) begin
      n_bad++;
      $display("FAIL rstmid_reach: deintegrate never reached within 200 cycles");
    end
    repeat (4) @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    #1;
    n_cmp++;
    if ({busy_o, integrate_sw_o, deintegrate_sw_o, measurement_en_o, result_valid_o, overrange_o} !== 6'b0 ||
        result_o !== 12'd0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: busy=%0b deint=%0b en=%0b result=%0d want all 0",
               busy_o, deintegrate_sw_o, measurement_en_o, result_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    comparator_i = 1'b0;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if (busy_o !== 1'b0 || result_o !== 12'd0) begin
      n_bad++;
      $display("FAIL rstmid_idle: busy=%0b result=%0d want 0/0", busy_o, result_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_overrange();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
